// File: rtl/sdram_wb_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module : sdram_wb_pattern_gen
// Desc   : Wishbone master that writes an incrementing burst to the SDRAM host
//          port, reads it back and reports mismatches and timeouts.
// Rev    : 1.0 - initial release
// ============================================================================
module sdram_wb_pattern_gen #(
   parameter int          APP_AW  = 26,
   parameter int          LEN_W   = 9,
   parameter logic [31:0] SEED    = 32'hA5A5_0000,
   parameter int          TIMEOUT = 1023
) (
   input  logic              sys_clk,
   input  logic              wb_rst_i,
   input  logic              sdr_init_done,
   input  logic              start,
   input  logic [APP_AW-1:0] base_addr,
   input  logic [LEN_W-1:0]  burst_len,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [APP_AW-1:0] wb_addr_o,
   output logic [31:0]       wb_dat_o,
   output logic [3:0]        wb_sel_o,
   input  logic              wb_ack_i,
   input  logic [31:0]       wb_dat_i,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              timeout,
   output logic [LEN_W-1:0]  err_count,
   output logic [APP_AW-1:0] first_err_addr
);

   localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_INIT = 3'd1,
      ST_WRITE     = 3'd2,
      ST_TURN      = 3'd3,
      ST_READ      = 3'd4,
      ST_FINISH    = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [LEN_W-1:0]    r_idx;
   logic [LEN_W-1:0]    r_len;
   logic [APP_AW-1:0]   r_base;
   logic [c_WD_W-1:0]   r_wd;

   logic                w_stb;
   logic                w_ack;
   logic                w_last;
   logic                w_accept;
   logic                w_wd_expire;
   logic                w_mismatch;
   logic [APP_AW-1:0]   w_addr;
   logic [31:0]         w_exp;

   assign w_stb       = (r_state == ST_WRITE) || (r_state == ST_READ);
   assign w_ack       = w_stb & wb_ack_i;
   assign w_last      = (r_idx == r_len - LEN_W'(1));
   assign w_accept    = (r_state == ST_IDLE) & start;
   // Expiry fires on the edge that would make the count equal TIMEOUT, so stb stays up exactly TIMEOUT cycles.
   assign w_wd_expire = w_stb & ~wb_ack_i & (r_wd == c_WD_LAST);
   assign w_addr      = r_base + APP_AW'({r_idx, 2'b00});
   assign w_exp       = SEED + 32'(r_idx);
   assign w_mismatch  = (r_state == ST_READ) & wb_ack_i & (wb_dat_i != w_exp);

   assign wb_cyc_o  = (r_state == ST_WRITE) || (r_state == ST_TURN) || (r_state == ST_READ);
   assign wb_stb_o  = w_stb;
   assign wb_we_o   = (r_state == ST_WRITE);
   assign wb_addr_o = w_stb ? w_addr : '0;
   assign wb_dat_o  = (r_state == ST_WRITE) ? w_exp : 32'd0;
   assign wb_sel_o  = w_stb ? 4'hF : 4'h0;

   always_ff @(posedge sys_clk) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_WAIT_INIT;
         end
         ST_WAIT_INIT: begin
            if (sdr_init_done) begin
               if (r_len == '0) w_next = ST_FINISH;
               else             w_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (w_wd_expire)          w_next = ST_FINISH;
            else if (w_ack && w_last) w_next = ST_TURN;
         end
         ST_TURN: begin
            w_next = ST_READ;
         end
         ST_READ: begin
            if (w_wd_expire)          w_next = ST_FINISH;
            else if (w_ack && w_last) w_next = ST_FINISH;
         end
         ST_FINISH: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (wb_rst_i) begin
         r_idx          <= '0;
         r_len          <= '0;
         r_base         <= '0;
         r_wd           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         timeout        <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         if (w_ack || (w_next != r_state)) begin
            r_wd <= '0;
         end else if (w_stb) begin
            r_wd <= r_wd + c_WD_W'(1);
         end

         if (r_state == ST_WAIT_INIT) begin
            r_idx <= '0;
         end else if (w_ack) begin
            r_idx <= w_last ? '0 : r_idx + LEN_W'(1);
         end

         if (w_accept) begin
            r_base         <= base_addr & ~APP_AW'(3);
            r_len          <= burst_len;
            busy           <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
         end

         if (w_wd_expire) begin
            timeout <= 1'b1;
            error   <= 1'b1;
         end

         if (w_mismatch) begin
            error <= 1'b1;
            if (err_count == '0) first_err_addr <= w_addr;
            if (err_count != '1) err_count <= err_count + LEN_W'(1);
         end

         if (r_state == ST_FINISH) begin
            done <= 1'b1;
            busy <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_wb_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_sdram_wb_pattern_gen
// Desc   : Directed self-checking bench for sdram_wb_pattern_gen with a
//          memory-backed Wishbone slave model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sdram_wb_pattern_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sdr_init_done = 1'b0;
   logic        start = 1'b0;
   logic [25:0] base_addr = '0;
   logic [8:0]  burst_len = '0;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [25:0] wb_addr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i = 1'b0;
   logic [31:0] wb_dat_i = '0;
   logic        busy, done, error, timeout;
   logic [8:0]  err_count;
   logic [25:0] first_err_addr;

   int n_cmp  = 0;
   int n_fail = 0;

   // slave model state
   logic        no_ack = 1'b0;
   logic [25:0] corrupt_addr = 26'h3FF_FFFF;
   int          wait_cnt = 0;
   logic [31:0] mem [0:1023];
   int          log_n = 0;
   logic        log_we   [0:255];
   logic [25:0] log_addr [0:255];
   logic [31:0] log_dat  [0:255];
   int          stb_cnt = 0;
   int          cyc_cnt = 0;
   int          turn_cnt = 0;
   int          sel_bad = 0;

   sdram_wb_pattern_gen #(
      .APP_AW (26),
      .LEN_W  (9),
      .SEED   (32'hA5A5_0000),
      .TIMEOUT(1023)
   ) dut (
      .sys_clk       (clk),
      .wb_rst_i      (rst),
      .sdr_init_done (sdr_init_done),
      .start         (start),
      .base_addr     (base_addr),
      .burst_len     (burst_len),
      .wb_cyc_o      (wb_cyc_o),
      .wb_stb_o      (wb_stb_o),
      .wb_we_o       (wb_we_o),
      .wb_addr_o     (wb_addr_o),
      .wb_dat_o      (wb_dat_o),
      .wb_sel_o      (wb_sel_o),
      .wb_ack_i      (wb_ack_i),
      .wb_dat_i      (wb_dat_i),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .timeout       (timeout),
      .err_count     (err_count),
      .first_err_addr(first_err_addr)
   );

   always #5 clk = ~clk;

   // Slave acks on the second cycle of each strobe and holds ack for one edge.
   always @(negedge clk) begin
      if (wb_ack_i) begin
         wb_ack_i = 1'b0;
         wait_cnt = 0;
      end else if (wb_cyc_o && wb_stb_o && !no_ack) begin
         wait_cnt++;
         if (wait_cnt >= 2) begin
            wb_ack_i = 1'b1;
            if (wb_we_o) mem[wb_addr_o[11:2]] = wb_dat_o;
            else wb_dat_i = (wb_addr_o == corrupt_addr) ? 32'd0 : mem[wb_addr_o[11:2]];
            if (log_n < 256) begin
               log_we[log_n]   = wb_we_o;
               log_addr[log_n] = wb_addr_o;
               log_dat[log_n]  = wb_we_o ? wb_dat_o : wb_dat_i;
               log_n++;
            end
         end
      end else begin
         wait_cnt = 0;
      end
      if (wb_stb_o) stb_cnt++;
      if (wb_cyc_o) cyc_cnt++;
      if (wb_cyc_o && !wb_stb_o) turn_cnt++;
      if (wb_stb_o && wb_sel_o != 4'hF) sel_bad++;
   end

   task automatic do_start(input logic [25:0] b, input logic [8:0] l);
      @(negedge clk);
      start = 1'b1; base_addr = b; burst_len = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'd0) begin
         n_fail++; $display("FAIL reset_bus: got %b want 0000000", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o});
      end
      n_cmp++;
      if ({wb_addr_o, wb_dat_o} !== 58'd0) begin
         n_fail++; $display("FAIL reset_addr_dat: got %h/%h want 0/0", wb_addr_o, wb_dat_o);
      end
      n_cmp++;
      if ({busy, done, error, timeout} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, error, timeout});
      end
      n_cmp++;
      if ({err_count, first_err_addr} !== 35'd0) begin
         n_fail++; $display("FAIL reset_err: got %h/%h want 0/0", err_count, first_err_addr);
      end
   endtask

   task automatic test_basic();
      int b, t0;
      bit ok;
      logic [58:0] got, exp;
      sdr_init_done = 1'b1;
      b = log_n; t0 = turn_cnt;
      do_start(26'h100, 9'd4);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL t1_busy: got %b want 1", busy);
      end
      wait_done(200, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++; $display("FAIL t1_done_wait: got done=%b want 1", done);
      end
      n_cmp++;
      if (log_n - b !== 8) begin
         n_fail++; $display("FAIL t1_xfer_count: got %0d want 8", log_n - b);
      end
      for (int i = 0; i < 8; i++) begin
         int k;
         k = i % 4;
         exp = {(i < 4), 26'h100 + 26'(4 * k), 32'hA5A5_0000 + 32'(k)};
         got = {log_we[b+i], log_addr[b+i], log_dat[b+i]};
         n_cmp++;
         if (got !== exp) begin
            n_fail++; $display("FAIL t1_xfer%0d: got %h want %h", i, got, exp);
         end
      end
      n_cmp++;
      if ({done, error, timeout, busy, err_count} !== {4'b1000, 9'd0}) begin
         n_fail++; $display("FAIL t1_status: got %b/%0d want 1000/0", {done, error, timeout, busy}, err_count);
      end
      n_cmp++;
      if (turn_cnt - t0 !== 1) begin
         n_fail++; $display("FAIL t1_turnaround: got %0d want 1", turn_cnt - t0);
      end
      n_cmp++;
      if (sel_bad !== 0) begin
         n_fail++; $display("FAIL t1_sel: got %0d bad cycles want 0", sel_bad);
      end
   endtask

   task automatic test_corrupt();
      int b;
      bit ok;
      b = log_n;
      corrupt_addr = 26'h108;
      do_start(26'h100, 9'd4);
      wait_done(200, ok);
      corrupt_addr = 26'h3FF_FFFF;
      n_cmp++;
      if (!ok || log_n - b !== 8) begin
         n_fail++; $display("FAIL t2_xfers: got done=%b n=%0d want 1/8", done, log_n - b);
      end
      n_cmp++;
      if (err_count !== 9'd1) begin
         n_fail++; $display("FAIL t2_err_count: got %0d want 1", err_count);
      end
      n_cmp++;
      if (first_err_addr !== 26'h108) begin
         n_fail++; $display("FAIL t2_first_err: got %h want 108", first_err_addr);
      end
      n_cmp++;
      if ({done, error, timeout} !== 3'b110) begin
         n_fail++; $display("FAIL t2_flags: got %b want 110", {done, error, timeout});
      end
   endtask

   task automatic test_init_wait();
      int b, s;
      bit ok;
      logic [58:0] got;
      sdr_init_done = 1'b0;
      b = log_n; s = stb_cnt;
      do_start(26'h100, 9'd4);
      repeat (50) @(negedge clk);
      n_cmp++;
      if (stb_cnt - s !== 0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL t3_hold: got stb=%0d busy=%b want 0/1", stb_cnt - s, busy);
      end
      sdr_init_done = 1'b1;
      wait_done(200, ok);
      got = {log_we[b], log_addr[b], log_dat[b]};
      n_cmp++;
      if (!ok || log_n - b !== 8 || got !== {1'b1, 26'h100, 32'hA5A5_0000}) begin
         n_fail++; $display("FAIL t3_run: got done=%b n=%0d first=%h want 1/8/%h", done, log_n - b, got, {1'b1, 26'h100, 32'hA5A5_0000});
      end
      n_cmp++;
      if ({error, err_count} !== 10'd0) begin
         n_fail++; $display("FAIL t3_err: got %b/%0d want 0/0", error, err_count);
      end
   endtask

   task automatic test_timeout();
      int b, s;
      bit ok;
      no_ack = 1'b1;
      b = log_n; s = stb_cnt;
      do_start(26'h100, 9'd4);
      wait_done(1200, ok);
      no_ack = 1'b0;
      n_cmp++;
      if (stb_cnt - s !== 1023) begin
         n_fail++; $display("FAIL t4_stb_cycles: got %0d want 1023", stb_cnt - s);
      end
      n_cmp++;
      if ({ok, done, error, timeout, wb_cyc_o} !== 5'b11110) begin
         n_fail++; $display("FAIL t4_flags: got %b want 11110", {ok, done, error, timeout, wb_cyc_o});
      end
      n_cmp++;
      if (log_n - b !== 0) begin
         n_fail++; $display("FAIL t4_xfers: got %0d want 0", log_n - b);
      end
   endtask

   task automatic test_zero_len();
      int b, c;
      bit ok;
      b = log_n; c = cyc_cnt;
      @(negedge clk);
      start = 1'b1; base_addr = 26'h100; burst_len = 9'd0;
      @(negedge clk);
      base_addr = 26'h200; burst_len = 9'd4;
      @(negedge clk);
      start = 1'b0;
      wait_done(10, ok);
      repeat (20) @(negedge clk);
      n_cmp++;
      if (cyc_cnt - c !== 0 || log_n - b !== 0) begin
         n_fail++; $display("FAIL t5_no_bus: got cyc=%0d xfers=%0d want 0/0", cyc_cnt - c, log_n - b);
      end
      n_cmp++;
      if ({ok, done, busy, error} !== 4'b1100) begin
         n_fail++; $display("FAIL t5_flags: got %b want 1100", {ok, done, busy, error});
      end
   endtask

   task automatic test_reset_mid();
      int b, n;
      bit ok;
      logic [58:0] got, exp;
      b = log_n; n = 0;
      do_start(26'h100, 9'd8);
      while (log_n - b < 3 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      n_cmp++;
      if (log_n - b < 3) begin
         n_fail++; $display("FAIL t6_reach_idx3: got %0d writes want 3", log_n - b);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({wb_cyc_o, wb_stb_o, busy, done} !== 4'b0000) begin
         n_fail++; $display("FAIL t6_abort: got %b want 0000", {wb_cyc_o, wb_stb_o, busy, done});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      b = log_n;
      do_start(26'h100, 9'd4);
      wait_done(200, ok);
      n_cmp++;
      if (!ok || log_n - b !== 8 || error !== 1'b0) begin
         n_fail++; $display("FAIL t6_rerun: got done=%b n=%0d err=%b want 1/8/0", done, log_n - b, error);
      end
      for (int i = 0; i < 8; i += 3) begin
         int k;
         k = i % 4;
         exp = {(i < 4), 26'h100 + 26'(4 * k), 32'hA5A5_0000 + 32'(k)};
         got = {log_we[b+i], log_addr[b+i], log_dat[b+i]};
         n_cmp++;
         if (got !== exp) begin
            n_fail++; $display("FAIL t6_xfer%0d: got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int b;
      bit ok;
      b = log_n;
      do_start(26'h100, 9'd2);
      repeat (4) @(negedge clk);
      do_start(26'h300, 9'd1);
      wait_done(200, ok);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (!ok || log_n - b !== 4 || busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_count: got done=%b n=%0d busy=%b want 1/4/0", done, log_n - b, busy);
      end
      n_cmp++;
      if (log_addr[b+1] !== 26'h104 || log_addr[b+3] !== 26'h104) begin
         n_fail++; $display("FAIL b2b_addr: got %h/%h want 104/104", log_addr[b+1], log_addr[b+3]);
      end
   endtask

   task automatic test_wrap();
      int b;
      bit ok;
      logic [58:0] got, exp;
      b = log_n;
      do_start(26'h3FF_FFFE, 9'd2);
      wait_done(200, ok);
      n_cmp++;
      if (!ok || log_n - b !== 4 || error !== 1'b0) begin
         n_fail++; $display("FAIL wrap_run: got done=%b n=%0d err=%b want 1/4/0", done, log_n - b, error);
      end
      for (int i = 0; i < 4; i++) begin
         int k;
         k = i % 2;
         exp = {(i < 2), 26'h3FF_FFFC + 26'(4 * k), 32'hA5A5_0000 + 32'(k)};
         got = {log_we[b+i], log_addr[b+i], log_dat[b+i]};
         n_cmp++;
         if (got !== exp) begin
            n_fail++; $display("FAIL wrap_xfer%0d: got %h want %h", i, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corrupt();
      test_init_wait();
      test_timeout();
      test_zero_len();
      test_reset_mid();
      test_back_to_back();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no completion want completion");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
